// File: rtl/ex_div_seq.sv
// ex_div_seq: iterative RV32M divide sequencer for the execute stage.
// Runs DIV/DIVU/REM/REMU as a 32-step restoring division on operand
// magnitudes, applies the sign fix, and presents the result for one cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst_ni      asynchronous active-low reset
//   start_i     valid, unsquashed divide in EX (held until done_o)
//   kill_i      squash of the EX instruction; aborts any operation
//   func3_i     100 DIV, 101 DIVU, 110 REM, 111 REMU (bit 2 ignored)
//   dividend_i  rs1 value
//   divisor_i   rs2 value
//   stall_o     freeze IF/ID/EX and hold EX-MA
//   busy_o      sequencer not idle
//   done_o      result_o valid this cycle
//   result_o    quotient or remainder
module ex_div_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] q_q, q_d;          // quotient shift register
  logic [XLEN:0]   rem_q, rem_d;      // partial remainder
  logic [XLEN-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            q_neg_q, q_neg_d;  // negate quotient in FIX
  logic            r_neg_q, r_neg_d;  // negate remainder in FIX
  logic            rem_sel_q, rem_sel_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed;
  logic            dvd_neg;
  logic            dvs_neg;
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] q_shift;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;

  logic unused_func3;
  assign unused_func3 = func3_i[2];

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_sel_d = rem_sel_q;
    result_d  = result_q;

    is_signed = ~func3_i[0];
    dvd_neg   = is_signed & dividend_i[XLEN-1];
    dvs_neg   = is_signed & divisor_i[XLEN-1];
    rem_shift = {rem_q[XLEN-1:0], q_q[XLEN-1]};
    q_shift   = {q_q[XLEN-2:0], 1'b0};
    quot_fix  = q_neg_q ? (~q_q + XLEN'(1)) : q_q;
    rem_fix   = r_neg_q ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];

    if (kill_i) begin
      // Squash: discard everything in flight, result register untouched.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            rem_sel_d = func3_i[1];
            q_neg_d   = dvd_neg ^ dvs_neg;
            r_neg_d   = dvd_neg;
            if (divisor_i == '0) begin
              // Divide by zero bypasses the datapath; remainder is raw rs1.
              result_d = func3_i[1] ? dividend_i : '1;
              state_d  = DONE;
            end else begin
              q_d     = dvd_neg ? (~dividend_i + XLEN'(1)) : dividend_i;
              dvs_d   = dvs_neg ? (~divisor_i + XLEN'(1)) : divisor_i;
              rem_d   = '0;
              cnt_d   = CW'(XLEN - 1);
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (rem_shift >= {1'b0, dvs_q}) begin
            rem_d = rem_shift - {1'b0, dvs_q};
            q_d   = q_shift | XLEN'(1);
          end else begin
            rem_d = rem_shift;
            q_d   = q_shift;
          end
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        FIX: begin
          result_d = rem_sel_q ? rem_fix : quot_fix;
          state_d  = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      q_q       <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_sel_q <= rem_sel_d;
      result_q  <= result_d;
    end
  end

  // Outputs are qualified by rst_ni so a held start_i cannot raise stall
  // while reset is asserted.
  always_comb begin
    stall_o  = rst_ni & ~kill_i &
               (((state_q == IDLE) & start_i) | (state_q == CALC) | (state_q == FIX));
    busy_o   = (state_q != IDLE);
    done_o   = rst_ni & ~kill_i & (state_q == DONE);
    result_o = result_q;
  end

endmodule

// File: tb/tb_ex_div_seq.sv
module tb_ex_div_seq;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic        kill_i;
  logic [2:0]  func3_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_err = 0;

  ex_div_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .kill_i     (kill_i),
    .func3_i    (func3_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is positioned #1 after a posedge with the DUT idle. Returns
  // positioned #1 after the edge that leaves DONE, start_i still high so a
  // following call starts back-to-back.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_cycles);
    int stalls = 0;
    int done_at = -1;
    logic [31:0] res = '0;
    logic stall_at_done = 1'b1;
    start_i    = 1'b1;
    func3_i    = f3;
    dividend_i = a;
    divisor_i  = b;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (done_o) begin
        done_at       = k;
        res           = result_o;
        stall_at_done = stall_o;
      end
    end
    check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_cycles));
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_cycles));
    check({tag, "_stall_in_done"}, {31'd0, stall_at_done}, 32'd0);
    check({tag, "_result"}, res, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    kill_i     = 1'b0;
    func3_i    = 3'b000;
    dividend_i = '0;
    divisor_i  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall",  {31'd0, stall_o}, 32'd0);
    check("rst_busy",   {31'd0, busy_o},  32'd0);
    check("rst_done",   {31'd0, done_o},  32'd0);
    check("rst_result", result_o,         32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Unsigned, signed and overflow operations, all back-to-back
    run_op("divu_100_7",  3'b101, 32'd100,        32'd7,          32'd14,         34);
    run_op("remu_100_7",  3'b111, 32'd100,        32'd7,          32'd2,          34);
    run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
    run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
    run_op("rem_7_m2",    3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          34);
    run_op("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34);
    run_op("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34);

    // Divide by zero
    run_op("divu_5_0",    3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    run_op("rem_m5_0",    3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1);

    // Result register holds outside DONE
    start_i = 1'b0;
    @(negedge clk);
    check("hold_result", result_o, 32'hFFFF_FFFB);
    check("idle_busy",   {31'd0, busy_o}, 32'd0);
    @(posedge clk); #1;

    // Kill at cycle 10 of DIVU 1000 / 3
    start_i    = 1'b1;
    func3_i    = 3'b101;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    kill_i = 1'b1;
    @(negedge clk);
    check("kill_stall", {31'd0, stall_o}, 32'd0);
    check("kill_done",  {31'd0, done_o},  32'd0);
    check("kill_busy",  {31'd0, busy_o},  32'd1);
    @(posedge clk); #1;
    kill_i  = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check("post_kill_busy", {31'd0, busy_o}, 32'd0);
    check("post_kill_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 34);

    // Asynchronous reset mid-CALC (cycle 15), start_i still held
    func3_i    = 3'b100;
    dividend_i = 32'd1000;
    divisor_i  = 32'd7;
    repeat (15) @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_stall",  {31'd0, stall_o}, 32'd0);
    check("arst_busy",   {31'd0, busy_o},  32'd0);
    check("arst_done",   {31'd0, done_o},  32'd0);
    check("arst_result", result_o,         32'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    rst_ni  = 1'b1;
    @(posedge clk); #1;
    run_op("div_20_m4", 3'b100, 32'd20, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 34);
    start_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Iterative RV32M divide sequencer attached to the execute stage. It accepts a DIV/DIVU/REM/REMU operation while the instruction sits in EX and holds the pipeline via `stall_o` while it runs a 32-step restoring division. It then presents the result for one cycle so the EX-MA register can capture it. It is also the owner of the shared divider datapath and handles the squash, divide-by-zero and overflow corner cases.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk`, in, 1: rising-edge clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `start_i`, in, 1: a valid, unsquashed divide instruction is in EX. Level signal, held until `done_o`.
- `kill_i`, in, 1: squash of the EX instruction. Aborts any operation.
- `func3_i`, in, 3: instruction func3. Decodes as 100 DIV, 101 DIVU, 110 REM, 111 REMU. Bit 2 is ignored.
- `dividend_i`, in, 32: rs1 value. Stable while `start_i` is high.
- `divisor_i`, in, 32: rs2 value. Stable while `start_i` is high.
- `stall_o`, out, 1: freeze IF/ID/EX and hold the EX-MA register.
- `busy_o`, out, 1: state ≠ IDLE.
- `done_o`, out, 1: `result_o` is valid this cycle.
- `result_o`, out, 32: quotient or remainder.

## Operation
- **State machine.** States are IDLE, CALC, FIX and DONE.
- **IDLE.**
  - If `start_i && !kill_i`:
    - Latch the operands, op and signedness (signed = !func3[0]).
    - Divisor == 0 → go to DONE with the special result.
    - Otherwise → load |dividend| into the quotient shift register, clear the 33-bit partial remainder, set step count to 31, go to CALC.
- **CALC.**
  - Each cycle: rem = {rem[31:0], q[31]}; q <<= 1.
  - If rem ≥ {1'b0, |divisor|}, subtract and set q[0] = 1.
  - Leave CALC after the step with count 0; otherwise decrement the count.
  - Magnitudes are computed as unsigned 32-bit values, so |−2^31| = 0x80000000.
- **FIX.**
  - Quotient sign = sign(dividend) XOR sign(divisor), signed ops only.
  - Remainder sign = sign(dividend), signed ops only.
  - Negate the magnitudes in two's complement as required.
  - Select quotient (func3[1] = 0) or remainder (func3[1] = 1) into the result register.
  - Go to DONE.
- **DONE.**
  - `done_o` = 1 and `result_o` = result register.
  - Go to IDLE on the next edge unconditionally.
- **Divide by zero.** Quotient = 0xFFFFFFFF; remainder = dividend (raw, no sign fix).
- **Overflow (DIV 0x80000000 / −1).** No special case: the algorithm yields quotient 0x80000000 and remainder 0, as the ISA requires.
- **Kill.**
  - `kill_i` in any state → next state IDLE.
  - `done_o` and `stall_o` are forced to 0 in that cycle; the partial result is discarded.
- **Reset.**
  - Async assert → IDLE immediately.
  - `stall_o`, `busy_o`, `done_o` = 0; `result_o` = 0; all internal registers cleared.
  - Reset mid-CALC leaves no residual state.

## Timing
- **`stall_o`** (combinational) = !kill_i && ((IDLE && start_i) || CALC || FIX).
  - It is low in DONE, so the EX-MA register captures `result_o` and the instruction leaves EX at the same edge.
- **Normal op.**
  - Cycle 0: IDLE with `start_i`.
  - Cycles 1–32: CALC.
  - Cycle 33: FIX.
  - Cycle 34: DONE.
  - `stall_o` is high for 34 cycles (0–33); `done_o` is high only in cycle 34.
- **Divide by zero.** Cycle 0 IDLE, cycle 1 DONE. `stall_o` is high 1 cycle.
- **Back-to-back.** A new `start_i` in the cycle after DONE (back in IDLE) starts a fresh operation. There is no dead cycle beyond DONE → IDLE.
- **`start_i` outside IDLE.** Ignored, since operands are already latched.
- **`kill_i` with `start_i` in IDLE.** The operation is not started.
- **`result_o`.** Holds its last value outside DONE. Only DONE-qualified use is legal.

## Test plan
- DIVU 100 / 7, `start_i` at cycle 0 → `stall_o` high cycles 0–33; `done_o` at cycle 34 with `result_o` = 14. Repeat as REMU → 2.
- DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). REM 7 / −2 → 1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0. Both take 34 stall cycles.
- DIVU 5 / 0 → 0xFFFFFFFF at cycle 1. REM −5 / 0 → 0xFFFFFFFB at cycle 1. `stall_o` high only at cycle 0.
- Start DIVU 1000 / 3, assert `kill_i` at cycle 10 → `stall_o` = 0 that cycle, IDLE next cycle, no `done_o`. Then start DIVU 9 / 3 immediately → `result_o` = 3 after 34 cycles.
- Deassert `rst_ni` mid-CALC (cycle 15), asynchronously between edges → all outputs 0 before the next edge. After release, DIV 20 / −4 → 0xFFFFFFFB.
